sd_sample_unpacker: RTL
=======================

# sd_sample_unpacker

FPGA-side consumer of the SD data FIFO, attached to the `rd_en1`/`rd_dat1` side of `spi_fpga_mux` when `fpga_mode` is set. Pulls bytes one at a time from the SD read FIFO and assembles them into little-endian multichannel PCM frames. Presents each frame on a valid/ready stream to the audio playback path. Tracks 512-byte block boundaries and flags underruns.

## Interface
- `SAMPLE_W`, 16: bits per channel sample. Must be 8, 16 or 24.
- `CHANNELS`, 2: samples per frame, 1..8.
- `clk` input 1: system clock, same domain as `sdc_controller`.
- `rstn_async` input 1: reset, asynchronous, active-low.
- `enable` input 1: run request.
- `fifo_empty` input 1: SD read FIFO empty, registered by the FIFO.
- `rd_en` output 1: FIFO pop strobe.
- `rd_dat` input 8: FIFO data, valid in the cycle after `rd_en`.
- `out_data` output CHANNELS*SAMPLE_W: frame; channel 0 in bits [SAMPLE_W-1:0].
- `out_valid` output 1: frame valid.
- `out_ready` input 1: consumer accepts the frame.
- `block_done` output 1: one-cycle pulse when the 512th byte of a block is captured.
- `underrun` output 1: sticky; cleared only by reset.

## Operation
- FB = CHANNELS*SAMPLE_W/8 is the number of bytes per frame.
- Fetch FSM states:
  - IDLE → REQ when `enable`=1 and the assembly register is free.
  - REQ: assert `rd_en` when `fifo_empty`=0, then go to CAP. Stay in REQ while the FIFO is empty.
  - CAP: write `rd_dat` into byte lane `byte_idx` of the assembly register and increment `byte_idx`.
    - If `byte_idx` was FB-1, mark the assembly register full and go to IDLE.
    - Otherwise go to REQ.
- At most one read is outstanding. `rd_en` is never asserted in CAP, so `fifo_empty` is always re-sampled after a pop.
- Byte order is little-endian within a sample; samples go channel 0 first.
- Transfer from the assembly register to the output register happens when the assembly register is full and (`out_valid`=0 or `out_ready`=1). Transfer takes one cycle and frees the assembly register.
  - If transfer and acceptance coincide, `out_valid` stays 1 with the new data.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- `blk_cnt` is 9 bits and increments on every CAP. It wraps from 511 to 0. `block_done` pulses on the CAP that wraps it.
- When `enable` falls mid-frame, the partial frame still completes. No new frame starts. `blk_cnt` is preserved, so block alignment persists across pauses.
- Underrun: in any cycle with `enable`=1, `out_ready`=1 and `out_valid`=0 after the first frame has been delivered, set `underrun`.

## Timing
- Reset value of all outputs and state is 0: `rd_en`, `out_valid`, `out_data`, `block_done`, `underrun`, `byte_idx`, `blk_cnt`, FSM=IDLE.
- With the FIFO non-empty, each byte costs 2 cycles (REQ, CAP).
- First `out_valid` appears 2*FB+2 cycles after `enable` rises: IDLE, 2*FB fetch cycles, then transfer. That is 10 cycles for 16-bit stereo.
- Sustained throughput is one frame per 2*FB+1 cycles, with fetch of the next frame overlapping the output hold.
- Reset asserted mid-frame discards the partial frame immediately. A `rd_en` pulse already issued is not undone; the popped byte is lost.
- `block_done` is registered and asserts the cycle after CAP.

## Configuration
- `SD_UNPACK_UNDERRUN_CNT_EN` defined: adds output `underrun_cnt` [15:0].
  - Counts underrun cycles and saturates at 16'hFFFF.
  - Reset value 0.
- `SD_UNPACK_UNDERRUN_CNT_EN` undefined: the port and counter are absent; only the sticky `underrun` flag exists.

## Structure
- Package `sd_stream_pkg` holds:
  - `BLOCK_BYTES`=512.
  - The fetch-state enum `fetch_state_t` {IDLE, REQ, CAP}.
  - The `FRAME_BYTES` function.
- Sub-module `sd_byte_fetch` owns the REQ/CAP handshake. It produces a `byte_vld`/`byte` pair plus `blk_cnt`/`block_done`. The top module holds the assembly and output registers.

## Test plan
- Reset, then FIFO preloaded with AB CD 12 34, `enable`=1, `out_ready`=1 → `out_data`=32'h3412CDAB at cycle 10, one `out_valid` pulse.
- Preload 512 bytes alternating AB/CD with `out_ready`=1 → 128 frames of 32'hCDABCDAB and one `block_done` pulse on the 512th capture. No `rd_en` is issued after the FIFO empties.
- `out_ready`=0 for 40 cycles with 3 frames queued → `out_data` stays stable and the assembly register fills. `rd_en` stops after 8 pops, and frames 2 and 3 follow in order once ready rises.
- FIFO empties after 2 bytes of a frame → FSM holds in REQ and `rd_en` stays 0. When bytes resume, the frame completes correctly. `underrun`=1, and with the macro defined `underrun_cnt` equals the exact gap length.
- `enable` drops after byte 1 → bytes 2–3 are still fetched and exactly one frame is output, then idle. Re-enable resumes with `blk_cnt` continuing from 4.
- `rstn_async` pulsed low mid-frame (after byte 1) → all outputs are 0 that cycle, and the next frame assembles from a fresh `byte_idx`=0.

Source files
------------

// File: rtl/sd_stream_pkg.sv
// Shared constants, fetch-state encoding and frame sizing
// for the SD sample unpacker.
package sd_stream_pkg;

  localparam int BLOCK_BYTES = 512;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAP
  } fetch_state_t;

  function automatic int FRAME_BYTES(input int sample_w,
                                     input int channels);
    return channels * sample_w / 8;
  endfunction

endpackage

// File: rtl/sd_byte_fetch.sv
// Single-outstanding byte fetcher for the SD read FIFO.
// Owns the REQ/CAP pop handshake, lane index and 512-byte block count.
module sd_byte_fetch
  import sd_stream_pkg::*;
#(
  parameter int FB = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rstn_async,
  input  logic          go_i,
  input  logic          fifo_empty_i,
  input  logic [7:0]    rd_dat_i,
  output logic          rd_en_o,
  output logic          byte_vld_o,
  output logic [7:0]    byte_o,
  output logic [IW-1:0] byte_idx_o,
  output logic          last_o,
  output logic          block_done_o
);

  fetch_state_t  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [8:0]    blk_cnt_q;
  logic          block_done_q;
  logic          cap;
  logic          last;

  assign cap  = (state_q == CAP);
  assign last = (idx_q == IW'(FB - 1));

  assign idx_d = !cap ? idx_q
               : last ? '0
               : idx_q + 1'b1;

  // Next state and pop strobe; never pop in CAP so empty is re-sampled
  always_comb begin
    state_d = state_q;
    rd_en_o = 1'b0;
    unique case (state_q)
      IDLE: if (go_i) state_d = REQ;
      REQ: begin
        if (!fifo_empty_i) begin
          rd_en_o = 1'b1;
          state_d = CAP;
        end
      end
      CAP: state_d = last ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
  end

  // State, lane index and block counter (block count survives pauses)
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      blk_cnt_q    <= '0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      block_done_q <= cap && (blk_cnt_q == 9'(BLOCK_BYTES - 1));
      if (cap) blk_cnt_q <= blk_cnt_q + 9'd1;
    end
  end

  assign byte_vld_o   = cap;
  assign byte_o       = rd_dat_i;
  assign byte_idx_o   = idx_q;
  assign last_o       = last;
  assign block_done_o = block_done_q;

endmodule

// File: rtl/sd_sample_unpacker.sv
// Assembles SD FIFO bytes into little-endian PCM frames on a valid/ready stream.
// Define SD_UNPACK_UNDERRUN_CNT_EN to add a saturating underrun_cnt output.
module sd_sample_unpacker
  import sd_stream_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rstn_async,
  input  logic                         enable,
  input  logic                         fifo_empty,
  output logic                         rd_en,
  input  logic [7:0]                   rd_dat,
  output logic [CHANNELS*SAMPLE_W-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         block_done,
  output logic                         underrun
`ifdef SD_UNPACK_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                  underrun_cnt
`endif
);

  localparam int FB = FRAME_BYTES(SAMPLE_W, CHANNELS);
  localparam int FW = CHANNELS * SAMPLE_W;
  localparam int IW = (FB > 1) ? $clog2(FB) : 1;

  logic          byte_vld;
  logic [7:0]    byte_dat;
  logic [IW-1:0] byte_idx;
  logic          byte_last;
  logic          go;
  logic          xfer;
  logic          ur_hit;

  logic [FW-1:0] asm_q;
  logic          asm_full_q;
  logic [FW-1:0] out_data_q;
  logic          out_valid_q;
  logic          delivered_q;
  logic          underrun_q;

  // Assembly frees in the same cycle it hands off, so fetch overlaps the hold
  assign xfer   = asm_full_q && (!out_valid_q || out_ready);
  assign go     = enable && (!asm_full_q || xfer);
  assign ur_hit = enable && out_ready && !out_valid_q && delivered_q;

  sd_byte_fetch #(
    .FB(FB),
    .IW(IW)
  ) u_fetch (
    .clk          (clk),
    .rstn_async   (rstn_async),
    .go_i         (go),
    .fifo_empty_i (fifo_empty),
    .rd_dat_i     (rd_dat),
    .rd_en_o      (rd_en),
    .byte_vld_o   (byte_vld),
    .byte_o       (byte_dat),
    .byte_idx_o   (byte_idx),
    .last_o       (byte_last),
    .block_done_o (block_done)
  );

  // Byte lanes fill channel 0 first, low byte first
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      asm_q      <= '0;
      asm_full_q <= 1'b0;
    end else begin
      for (int i = 0; i < FB; i++) begin
        if (byte_vld && byte_idx == IW'(i)) asm_q[8*i +: 8] <= byte_dat;
      end
      if (xfer) asm_full_q <= 1'b0;
      if (byte_vld && byte_last) asm_full_q <= 1'b1;
    end
  end

  // Output register; data holds while the consumer stalls
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      out_data_q  <= asm_q;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky underrun, armed once the first frame has been taken
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      delivered_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) delivered_q <= 1'b1;
      if (ur_hit) underrun_q <= 1'b1;
    end
  end

`ifdef SD_UNPACK_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt_q;

  // Saturating count of underrun cycles
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) ur_cnt_q <= '0;
    else if (ur_hit && ur_cnt_q != 16'hFFFF) ur_cnt_q <= ur_cnt_q + 16'd1;
  end

  assign underrun_cnt = ur_cnt_q;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule
